// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with per-message locking released by req_last or an idle timeout in HOLD.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_load,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    DRAIN  = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           last_q;

  logic           accept;
  logic [IDW-1:0] accept_id;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] release_ptr;

  logic [7:0] req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] = req_data[8*g +: 8];
  end

  // First valid requester at or after ptr, searching upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      end
      if (!win_found && req_valid[cand_sum[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand_sum[IDW-1:0];
      end
    end
  end

  assign release_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    accept    = 1'b0;
    accept_id = grant_id;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (tx_ready && win_found) begin
          accept    = 1'b1;
          accept_id = win_id;
          state_n   = LOAD;
        end
      end
      LOAD:   state_n = SETTLE;
      // The transmitter's ready register lags tx_load by a cycle, so skip it here.
      SETTLE: state_n = DRAIN;
      DRAIN: begin
        if (tx_ready) begin
          if (last_q) begin
            state_n = IDLE;
            ptr_n   = release_ptr;
          end else begin
            state_n = HOLD;
            cnt_n   = '0;
          end
        end
      end
      HOLD: begin
        if (tx_ready && req_valid[grant_id]) begin
          accept  = 1'b1;
          state_n = LOAD;
          cnt_n   = '0;
        end else if ((LOCK_TIMEOUT != 0) && !req_valid[grant_id] &&
                     (cnt == CW'(LOCK_TIMEOUT - 1))) begin
          state_n = IDLE;
          ptr_n   = release_ptr;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (accept && !rst) begin
      req_ready[accept_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      last_q   <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      if (accept) begin
        tx_data  <= req_byte[accept_id];
        grant_id <= accept_id;
        last_q   <= req_last[accept_id];
      end
    end
  end

  assign tx_load = (state == LOAD);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a small transmitter
// model, and a scoreboard of expected {grant_id, tx_data} checked on every tx_load.
module tb_uart_tx_arbiter;

  localparam int FRAME = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        grant_id;
  logic        busy;

  uart_tx_arbiter #(.NUM_REQ(2), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_load(tx_load), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int proto_err = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] exp_q[$];

  logic [1:0] acc = '0;
  int         tx_cnt = 0;
  logic       load_prev = 1'b0;
  logic       stall = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic drive();
    req_valid[0] = (q0.size() != 0);
    req_valid[1] = (q1.size() != 0);
    if (q0.size() != 0) {req_last[0], req_data[7:0]} = q0[0];
    else                {req_last[0], req_data[7:0]} = 9'h000;
    if (q1.size() != 0) {req_last[1], req_data[15:8]} = q1[0];
    else                {req_last[1], req_data[15:8]} = 9'h000;
  endtask

  // One clock: update transmitter model and requesters after the edge, sample mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst)            tx_cnt = 0;
    else if (load_prev) tx_cnt = FRAME;
    else if (tx_cnt > 0) tx_cnt--;
    load_prev = tx_load;
    tx_ready  = !stall && (tx_cnt == 0);
    if (acc[0] && q0.size() != 0) void'(q0.pop_front());
    if (acc[1] && q1.size() != 0) void'(q1.pop_front());
    drive();
    @(negedge clk);
    acc = req_ready & req_valid;
    if ((req_ready & ~req_valid) != 2'b00) proto_err++;
    if (req_ready == 2'b11) proto_err++;
    if (!tx_ready && req_ready != 2'b00) proto_err++;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    chk(name, done, 1);
  endtask

  always @(negedge clk) begin
    if (tx_load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", 1, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("load_grant", int'(grant_id), int'(e[8]));
        chk("load_data", int'(tx_data), int'(e[7:0]));
      end
    end
  end

  initial begin
    int hold_cnt;
    int stall_bad;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_tx_load", int'(tx_load), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    rst = 1'b0;
    tick();

    // Single byte from requester 0
    q0.push_back({1'b1, 8'h41});
    exp_q.push_back({1'b0, 8'h41});
    tick();
    chk("single_ready_same_cycle", int'(req_ready), 1);
    tick();
    chk("single_tx_load", int'(tx_load), 1);
    wait_idle("single_done", 50);

    // Pointer is now 1; reset while the grant to requester 1 sits in DRAIN
    q0.push_back({1'b1, 8'h52});
    q1.push_back({1'b1, 8'h61});
    q1.push_back({1'b1, 8'h62});
    exp_q.push_back({1'b1, 8'h61});
    tick();
    chk("ptr_after_single", int'(req_ready), 2);
    stall = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_drain_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("postrst_tx_load", int'(tx_load), 0);
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_grant", int'(grant_id), 0);
    chk("postrst_ready", int'(req_ready), 0);
    chk("postrst_tx_data", int'(tx_data), 0);
    exp_q.push_back({1'b0, 8'h52});
    exp_q.push_back({1'b1, 8'h62});
    stall = 1'b0;
    tick();
    chk("reaccept_from_ptr0", int'(req_ready), 1);
    wait_idle("reset_done", 100);

    // Simultaneous requests, every byte last: strict alternation from requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, 8'h10 + 8'(i)});
      q1.push_back({1'b1, 8'h20 + 8'(i)});
      exp_q.push_back({1'b0, 8'h10 + 8'(i)});
      exp_q.push_back({1'b1, 8'h20 + 8'(i)});
    end
    wait_idle("simul_done", 300);

    // Locked message from requester 1 while requester 0 waits
    q1.push_back({1'b0, 8'h48});
    q1.push_back({1'b0, 8'h49});
    q1.push_back({1'b1, 8'h0A});
    exp_q.push_back({1'b1, 8'h48});
    exp_q.push_back({1'b1, 8'h49});
    exp_q.push_back({1'b1, 8'h0A});
    exp_q.push_back({1'b0, 8'h30});
    tick();
    chk("lock_first_grant", int'(req_ready), 2);
    q0.push_back({1'b1, 8'h30});
    wait_idle("lock_done", 200);

    // Lock timeout: requester 0 sends an unfinished message and goes quiet
    q0.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b1, 8'h66});
    tick();
    chk("timeout_first_grant", int'(req_ready), 1);
    q1.push_back({1'b1, 8'h66});
    hold_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req_ready[1]) break;
      if (busy && tx_ready && !tx_load) hold_cnt++;
    end
    // Final DRAIN cycle with tx_ready high plus 16 HOLD cycles
    chk("timeout_hold_cycles", hold_cnt, 17);
    chk("timeout_r1_ready", int'(req_ready), 2);
    wait_idle("timeout_done", 100);

    // Transmitter stall for 40 cycles after tx_load
    q0.push_back({1'b1, 8'h77});
    exp_q.push_back({1'b0, 8'h77});
    exp_q.push_back({1'b1, 8'h78});
    tick();
    chk("stall_first_grant", int'(req_ready), 1);
    tick();
    stall = 1'b1;
    q1.push_back({1'b1, 8'h78});
    stall_bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tx_load || req_ready != 2'b00 || tx_data != 8'h77) stall_bad++;
    end
    chk("stall_quiet", stall_bad, 0);
    chk("stall_busy", int'(busy), 1);
    stall = 1'b0;
    wait_idle("stall_done", 100);

    chk("protocol", proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
